alu_mdu: RTL and testbench

Parametrised, handshaked successor to the processor's single-cycle ALU. It adds XOR, unsigned compare, shifts, an iterative unsigned multiplier and an iterative unsigned divider behind a valid/ready interface, and presents a registered result with a Zero flag. It sits in the execute stage. The core stalls on `in_ready`/`out_valid` so that multi-cycle operations can complete.

---
 rtl/alu_mdu_if.sv | 25 ++
 rtl/alu_mdu.sv | 121 ++++++++++++
 tb/tb_alu_mdu.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_mdu_if.sv
// Execute-stage ALU/MDU handshake bundle: operation request in, registered result out.
// The core drives the master side and the unit drives the slave side.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, op, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_mdu.sv
// Handshaked ALU with iterative shift-add multiplier and restoring divider.
// Simple ops finish on the accept edge; MUL/MULHU/DIVU/REMU take WIDTH+1 edges.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    alu_mdu_if.slave  io
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t             state, state_nx;
    req_t               req;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   alu_res;
    logic [SW-1:0]      shamt;
    logic               multi;
    logic               last;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;

    assign multi = (io.op[3:1] == 3'b101) || (io.op[3:1] == 3'b110);
    assign last  = (cnt == '0);
    assign shamt = io.src_b[SW-1:0];

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.result    = result_q;
    assign io.zero      = (result_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (io.in_valid) state_nx = multi ? BUSY : DONE;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (io.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (io.op)
            4'b0000: alu_res = io.src_a + io.src_b;
            4'b0001: alu_res = io.src_a - io.src_b;
            4'b0010: alu_res = io.src_a & io.src_b;
            4'b0011: alu_res = io.src_a | io.src_b;
            4'b0100: alu_res = io.src_a ^ io.src_b;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, $signed(io.src_a) < $signed(io.src_b)};
            4'b0110: alu_res = {{(WIDTH-1){1'b0}}, io.src_a < io.src_b};
            4'b0111: alu_res = io.src_a << shamt;
            4'b1000: alu_res = io.src_a >> shamt;
            4'b1001: alu_res = $signed(io.src_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Multiplier bit is prod[0]; the multiplicand adds into the upper half before the shift.
    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, req.a} : '0);
    assign div_sh  = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign div_ge  = (div_sh >= {1'b0, req.b});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req      <= '0;
            cnt      <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            result_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (io.in_valid) begin
                    req <= '{op: io.op, a: io.src_a, b: io.src_b};
                    if (multi) begin
                        cnt  <= CW'(WIDTH);
                        prod <= {{WIDTH{1'b0}}, io.src_b};
                        rem  <= '0;
                        quo  <= io.src_a;
                    end else begin
                        result_q <= alu_res;
                    end
                end
                BUSY: if (last) begin
                    unique case (req.op)
                        4'b1010: result_q <= prod[WIDTH-1:0];
                        4'b1011: result_q <= prod[2*WIDTH-1:WIDTH];
                        4'b1100: result_q <= quo;
                        default: result_q <= rem[WIDTH-1:0];
                    endcase
                end else begin
                    // Both engines step every cycle; the op selects which one is read out.
                    cnt  <= cnt - 1'b1;
                    prod <= {mul_sum, prod[WIDTH-1:1]};
                    rem  <= div_ge ? (div_sh - {1'b0, req.b}) : div_sh;
                    quo  <= {quo[WIDTH-2:0], div_ge};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at WIDTH=32 and WIDTH=8 with hand-computed expectations.
module tb_alu_mdu;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   lat, rh;

    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(32)) b32();
    alu_mdu_if #(.WIDTH(8))  b8();

    alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .io(b32));
    alu_mdu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .io(b8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op32(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int r);
        chk("idle_ready32", b32.in_ready, 1);
        b32.op = o; b32.src_a = a; b32.src_b = b; b32.in_valid = 1'b1;
        @(posedge clk); #1;
        b32.in_valid = 1'b0; b32.src_a = ~a; b32.src_b = ~b; b32.op = 4'hF;
        l = 0; r = 0;
        while (!b32.out_valid && l < 200) begin
            if (b32.in_ready) r++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic op8(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       output int l, output int r);
        chk("idle_ready8", b8.in_ready, 1);
        b8.op = o; b8.src_a = a; b8.src_b = b; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0; b8.src_a = ~a; b8.src_b = ~b; b8.op = 4'hF;
        l = 0; r = 0;
        while (!b8.out_valid && l < 200) begin
            if (b8.in_ready) r++;
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic t32(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int elat);
        int l, r;
        op32(o, a, b, l, r);
        chk({tag, "_lat"}, l, elat);
        chk({tag, "_busy_ready"}, r, 0);
        chk({tag, "_res"}, b32.result, exp);
        chk({tag, "_zero"}, b32.zero, exp == 32'd0);
        @(posedge clk); #1;
        chk({tag, "_hold_valid"}, b32.out_valid, 1);
        chk({tag, "_hold_res"}, b32.result, exp);
        b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        chk({tag, "_drain_valid"}, b32.out_valid, 0);
    endtask

    task automatic t8(input string tag, input logic [3:0] o, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp, input int elat);
        int l, r;
        op8(o, a, b, l, r);
        chk({tag, "_lat"}, l, elat);
        chk({tag, "_busy_ready"}, r, 0);
        chk({tag, "_res"}, b8.result, exp);
        chk({tag, "_zero"}, b8.zero, exp == 8'd0);
        b8.out_ready = 1'b1;
        @(posedge clk); #1;
        b8.out_ready = 1'b0;
        chk({tag, "_drain_valid"}, b8.out_valid, 0);
    endtask

    initial begin
        b32.in_valid = 1'b0; b32.op = 4'h0; b32.src_a = '0; b32.src_b = '0; b32.out_ready = 1'b0;
        b8.in_valid  = 1'b0; b8.op  = 4'h0; b8.src_a  = '0; b8.src_b  = '0; b8.out_ready  = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("rst_ready",  b32.in_ready, 1);
        chk("rst_valid",  b32.out_valid, 0);
        chk("rst_result", b32.result, 0);
        chk("rst_zero",   b32.zero, 1);
        chk("rst_ready8", b8.in_ready, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        t32("add",  4'b0000, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 0);
        t32("sub",  4'b0001, 32'd5,         32'd7,        32'hFFFF_FFFE, 0);
        t32("xor",  4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
        t32("slt",  4'b0101, 32'hFFFF_FFFF, 32'd1,        32'h0000_0001, 0);
        t32("sltu", 4'b0110, 32'hFFFF_FFFF, 32'd1,        32'h0000_0000, 0);
        t32("sra",  4'b1001, 32'h8000_0000, 32'h24,       32'hF800_0000, 0);
        t32("srl",  4'b1000, 32'h8000_0000, 32'h24,       32'h0800_0000, 0);
        t32("op_e", 4'b1110, 32'h1234_5678, 32'h1,        32'h0000_0000, 0);

        // Abort a divide mid-flight with in_valid still held.
        b32.op = 4'b1100; b32.src_a = 32'd100; b32.src_b = 32'd7; b32.in_valid = 1'b1;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_ready", b32.in_ready, 0);
        chk("busy_valid", b32.out_valid, 0);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid",  b32.out_valid, 0);
        chk("abort_result", b32.result, 0);
        chk("abort_zero",   b32.zero, 1);
        chk("abort_ready",  b32.in_ready, 1);
        b32.in_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        t32("mul",   4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
        t32("mulhu", 4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        t32("divu",  4'b1100, 32'd100, 32'd7, 32'd14, 33);
        t32("remu",  4'b1101, 32'd100, 32'd7, 32'd2,  33);
        t32("divu0", 4'b1100, 32'd9,   32'd0, 32'hFFFF_FFFF, 33);
        t32("remu0", 4'b1101, 32'd9,   32'd0, 32'd9,  33);

        // Backpressure: result held, new requests ignored, nothing queued.
        op32(4'b1100, 32'd100, 32'd7, lat, rh);
        chk("bp_lat", lat, 33);
        chk("bp_first", b32.result, 14);
        for (int i = 0; i < 10; i++) begin
            b32.op = 4'b0000; b32.src_a = 32'd1; b32.src_b = 32'd1; b32.in_valid = i[0];
            @(posedge clk); #1;
            chk("bp_valid",  b32.out_valid, 1);
            chk("bp_result", b32.result, 14);
            chk("bp_ready",  b32.in_ready, 0);
        end
        b32.in_valid = 1'b0; b32.out_ready = 1'b1;
        @(posedge clk); #1;
        b32.out_ready = 1'b0;
        chk("bp_xfer_valid", b32.out_valid, 0);
        chk("bp_xfer_ready", b32.in_ready, 1);
        @(posedge clk); #1;
        chk("bp_idle_valid",  b32.out_valid, 0);
        chk("bp_idle_ready",  b32.in_ready, 1);
        chk("bp_idle_result", b32.result, 14);

        t8("mul8",   4'b1010, 8'h10, 8'h10, 8'h00, 9);
        t8("mulhu8", 4'b1011, 8'h10, 8'h10, 8'h01, 9);
        t8("sll8",   4'b0111, 8'h01, 8'h0B, 8'h08, 0);
        t8("divu8",  4'b1100, 8'd200, 8'd9, 8'd22, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
